// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, round count and FSM encoding for the AES round controller
package aes_pkg;

  localparam int DATA_W     = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int ROUND_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - block input, datapath issue/return and ciphertext output bundle
interface aes_round_ctrl_if #(
  parameter int DATA_W = aes_pkg::DATA_W
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;

  logic                       dp_valid_out;
  logic [DATA_W-1:0]          dp_data_out;
  logic [aes_pkg::ROUND_W-1:0] dp_round;
  logic                       dp_last;
  logic                       dp_valid_in;
  logic [DATA_W-1:0]          dp_data_in;

  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;

  // master is the controller; slave is the upstream/datapath/downstream environment
  modport master (
    input  in_valid, in_data, dp_valid_in, dp_data_in, out_ready,
    output in_ready, dp_valid_out, dp_data_out, dp_round, dp_last, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, dp_valid_in, dp_data_in, out_ready,
    input  in_ready, dp_valid_out, dp_data_out, dp_round, dp_last, out_valid, out_data
  );

endinterface

// File: rtl/aes_round_wdog.sv
// rtl/aes_round_wdog.sv - WAIT-state watchdog: counts cycles in WAIT and raises a sticky error
module aes_round_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait,
  input  logic dp_valid_in,
  output logic timeout,
  output logic err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside WAIT, so every entry into WAIT starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!in_wait) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The TIMEOUT-th WAIT cycle; the error becomes visible TIMEOUT cycles after entry.
  assign timeout = in_wait && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (timeout && !dp_valid_in) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencer; optional WAIT watchdog under AES_ROUND_WDOG_EN
module aes_round_ctrl #(
  parameter int DATA_W     = aes_pkg::DATA_W,
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  aes_round_ctrl_if.master  bus,
  output logic              busy,
  output logic              err
);

  import aes_pkg::*;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS >= (1 << ROUND_W)) begin : g_bad_num_rounds
    $error("NUM_ROUNDS must fit the round index width");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  aes_state_e         fsm_q, fsm_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               last_round;
  logic               wdog_timeout;

  assign last_round = (round_q == LAST_ROUND);

`ifdef AES_ROUND_WDOG_EN
  aes_round_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .reset       (reset),
    .in_wait     (fsm_q == ST_WAIT),
    .dp_valid_in (bus.dp_valid_in),
    .timeout     (wdog_timeout),
    .err         (err)
  );
`else
  assign wdog_timeout = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      data_q  <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    round_d = round_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          round_d = '0;
          fsm_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fsm_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the watchdog's final cycle takes priority over the timeout.
        if (bus.dp_valid_in) begin
          data_d = bus.dp_data_in;
          if (last_round) begin
            fsm_d = ST_DONE;
          end else begin
            round_d = round_q + ROUND_W'(1);
            fsm_d   = ST_ISSUE;
          end
        end else if (wdog_timeout) begin
          round_d = '0;
          fsm_d   = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // Every output comes from registers only; nothing reaches out from in_data combinationally.
  always_comb begin
    bus.in_ready     = (fsm_q == ST_IDLE);
    bus.dp_valid_out = (fsm_q == ST_ISSUE);
    bus.dp_data_out  = data_q;
    bus.dp_round     = round_q;
    bus.dp_last      = last_round;
    bus.out_valid    = (fsm_q == ST_DONE);
    bus.out_data     = data_q;
    busy             = (fsm_q != ST_IDLE);
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl with a +1 registered stub datapath
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  logic         stub_valid = 1'b0;
  logic [127:0] stub_data  = '0;
  logic         stall_en   = 1'b0;
  logic         spur_valid = 1'b0;
  logic [127:0] spur_data  = '0;

  // Stub datapath: one-cycle latency, adds 1 to the state; can stall in round 3.
  always @(posedge clk) begin
    stub_valid <= bus.dp_valid_out && !(stall_en && bus.dp_round == 4'd3);
    stub_data  <= bus.dp_data_out + 128'd1;
  end

  assign bus.dp_valid_in = stub_valid | spur_valid;
  assign bus.dp_data_in  = spur_valid ? spur_data : stub_data;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [127:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    exp_q.push_back(d + 128'd11);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    logic [127:0] exp;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid timeout got=%b want=1", name, bus.out_valid);
    end else begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (bus.out_data !== exp) begin
        failures++;
        $display("FAIL %s out_data got=%h want=%h", name, bus.out_data, exp);
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    checks += 8;
    if (bus.in_ready !== 1'b1)     begin failures++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    if (bus.dp_valid_out !== 1'b0) begin failures++; $display("FAIL rst_dp_valid got=%b want=0", bus.dp_valid_out); end
    if (bus.out_valid !== 1'b0)    begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    if (busy !== 1'b0)             begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (err !== 1'b0)              begin failures++; $display("FAIL rst_err got=%b want=0", err); end
    if (bus.dp_round !== 4'd0)     begin failures++; $display("FAIL rst_round got=%0d want=0", bus.dp_round); end
    if (bus.dp_last !== 1'b0)      begin failures++; $display("FAIL rst_last got=%b want=0", bus.dp_last); end
    if (bus.out_data !== 128'd0)   begin failures++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_round_timing();
    logic exp_v;
    send(128'd0);
    for (int k = 1; k <= 23; k++) begin
      exp_v = (k % 2 == 1) && (k <= 21);
      checks += 2;
      if (bus.dp_valid_out !== exp_v) begin
        failures++;
        $display("FAIL v1_dp_valid k=%0d got=%b want=%b", k, bus.dp_valid_out, exp_v);
      end
      if (bus.out_valid !== (k == 23)) begin
        failures++;
        $display("FAIL v1_out_valid k=%0d got=%b want=%b", k, bus.out_valid, (k == 23));
      end
      if (exp_v) begin
        checks += 3;
        if (bus.dp_round !== 4'((k - 1) / 2)) begin
          failures++;
          $display("FAIL v1_dp_round k=%0d got=%0d want=%0d", k, bus.dp_round, (k - 1) / 2);
        end
        if (bus.dp_last !== (k == 21)) begin
          failures++;
          $display("FAIL v1_dp_last k=%0d got=%b want=%b", k, bus.dp_last, (k == 21));
        end
        if (bus.dp_data_out !== 128'((k - 1) / 2)) begin
          failures++;
          $display("FAIL v1_dp_data k=%0d got=%h want=%0d", k, bus.dp_data_out, (k - 1) / 2);
        end
      end
      if (k < 23) step();
    end
    wait_out("v1_result");
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [127:0] exp;
    bus.out_ready = 1'b0;
    send(128'h0123456789ABCDEF_FEDCBA9876543210);
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL v2_hold_valid i=%0d got=%b want=1", i, bus.out_valid); end
      if (bus.out_data !== exp)   begin failures++; $display("FAIL v2_hold_data i=%0d got=%h want=%h", i, bus.out_data, exp); end
      if (bus.in_ready !== 1'b0)  begin failures++; $display("FAIL v2_in_ready i=%0d got=%b want=0", i, bus.in_ready); end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL v2_release_valid got=%b want=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL v2_release_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] b = 128'h0011223344556677_8899AABBCCDDEEFF;
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h0000000000000000_00000000000000A0;
    exp_q.push_back(128'hB0 + 128'd1 - 128'd6);
    step();
    bus.in_data = b;
    wait_out("v3_first");
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL v3_idle_ready got=%b want=1", bus.in_ready); end
    exp_q.push_back(b + 128'd11);
    step();
    bus.in_valid = 1'b0;
    wait_out("v3_second");
  endtask

  task automatic test_spurious();
    spur_valid = 1'b1;
    spur_data  = {$urandom, $urandom, $urandom, $urandom};
    step();
    spur_valid = 1'b0;
    checks += 3;
    if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL v4_idle_ready got=%b want=1", bus.in_ready); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL v4_idle_busy got=%b want=0", busy); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL v4_idle_out got=%b want=0", bus.out_valid); end
    send(128'h5555);
    checks++;
    if (bus.dp_valid_out !== 1'b1) begin failures++; $display("FAIL v4_issue got=%b want=1", bus.dp_valid_out); end
    spur_valid = 1'b1;
    spur_data  = 128'hDEAD_BEEF;
    step();
    spur_valid = 1'b0;
    checks += 2;
    if (bus.dp_valid_out !== 1'b0) begin failures++; $display("FAIL v4_wait_dp got=%b want=0", bus.dp_valid_out); end
    if (bus.dp_round !== 4'd0)     begin failures++; $display("FAIL v4_wait_round got=%0d want=0", bus.dp_round); end
    wait_out("v4_result");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    send(128'h1234);
    for (int k = 2; k <= 11; k++) step();
    checks++;
    if (bus.dp_valid_out !== 1'b1 || bus.dp_round !== 4'd5) begin
      failures++;
      $display("FAIL v5_round5 got=%b/%0d want=1/5", bus.dp_valid_out, bus.dp_round);
    end
    step();
    reset = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checks += 4;
    if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL v5_in_ready got=%b want=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL v5_out_valid got=%b want=0", bus.out_valid); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL v5_busy got=%b want=0", busy); end
    if (bus.dp_round !== 4'd0)  begin failures++; $display("FAIL v5_round got=%0d want=0", bus.dp_round); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL v5_stale got=1 want=0"); end
    send(128'hFFFF_0000);
    wait_out("v5_fresh");
  endtask

`ifdef AES_ROUND_WDOG_EN
  task automatic test_watchdog();
    stall_en = 1'b1;
    send(128'h7);
    void'(exp_q.pop_back());
    for (int k = 2; k <= 23; k++) step();
    checks += 2;
    if (err !== 1'b0)  begin failures++; $display("FAIL v6_err_early got=%b want=0", err); end
    if (busy !== 1'b1) begin failures++; $display("FAIL v6_busy_early got=%b want=1", busy); end
    step();
    checks += 4;
    if (err !== 1'b1)          begin failures++; $display("FAIL v6_err got=%b want=1", err); end
    if (busy !== 1'b0)         begin failures++; $display("FAIL v6_busy got=%b want=0", busy); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL v6_in_ready got=%b want=1", bus.in_ready); end
    if (bus.dp_round !== 4'd0) begin failures++; $display("FAIL v6_round got=%0d want=0", bus.dp_round); end
    stall_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL v6_err_sticky got=%b want=1", err); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL v6_err_clear got=%b want=0", err); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_round_timing();
    test_backpressure();
    test_busy_ignore();
    test_spurious();
    test_reset_mid();
`ifdef AES_ROUND_WDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule
